// File: rtl/if_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
`timescale 1ns/1ps
// Generic DEPTH x WIDTH synchronous FIFO with flush; head is read straight
// from register storage, so a pushed word is visible on the following cycle.
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  // NOTE: storage is reset too, so the head reads as zero rather than X
  // before the first push; this is cheap at these depths.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_queue.sv
`timescale 1ns/1ps
// Instruction-fetch front end: PC generation, prefetch queue toward decode,
// redirect-with-flush and halt-sentinel finish detection with a drain delay.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT,
  parameter int          FIN_DELAY = 7
) (
  input  logic        CLOCK,
  input  logic        RESET,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic        fin
);

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [7:0]  FIN_LAST = 8'(FIN_DELAY - 1);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         halt_seen_q, halt_seen_d;
  logic [7:0]   drain_cnt_q, drain_cnt_d;
  logic         fin_q, fin_d;

  logic         fifo_full, fifo_empty, push, pop, fetch_en, is_halt;
  logic [CW-1:0] fifo_count;
  fetch_entry_t head, new_entry;
  logic [31:0]  redirect_aligned;

  assign redirect_aligned = redirect_pc & ~32'h3;
  assign is_halt   = (imem_data == HALT_WORD);
  assign fetch_en  = ~redirect_valid & ~halt_seen_q & ~fin_q;
  assign pop       = ~fifo_empty & out_ready & ~redirect_valid;
  assign push      = fetch_en & ~is_halt & (~fifo_full | pop);
  assign new_entry = '{pc: fetch_pc_q, instr: imem_data};

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i   (CLOCK),
    .rst_i   (RESET),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  (new_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (head)
  );

  // NOTE: every next-state signal gets a hold default first so that no
  // path through this block leaves one unassigned and infers a latch.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    halt_seen_d = halt_seen_q;
    drain_cnt_d = drain_cnt_q;
    fin_d       = fin_q;
    if (redirect_valid) begin
      fetch_pc_d  = redirect_aligned;
      halt_seen_d = 1'b0;
      drain_cnt_d = '0;
    end else begin
      if (push) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (fetch_en && is_halt) halt_seen_d = 1'b1;
      // Finish only once the sentinel is seen and decode has taken everything.
      if (halt_seen_q && fifo_count == '0 && !fin_q) begin
        if (drain_cnt_q == FIN_LAST) fin_d = 1'b1;
        else                         drain_cnt_d = drain_cnt_q + 8'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every
  // register samples the same pre-edge values.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      fetch_pc_q  <= RESET_PC;
      halt_seen_q <= 1'b0;
      drain_cnt_q <= '0;
      fin_q       <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      halt_seen_q <= halt_seen_d;
      drain_cnt_q <= drain_cnt_d;
      fin_q       <= fin_d;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = ~fifo_empty;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc : '0;
  assign out_pc4   = out_valid ? head.pc + PC_STEP : '0;
  assign fin       = fin_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
`timescale 1ns/1ps
// Self-checking bench for if_fetch_queue: scoreboard of expected {pc, instr}
// entries popped by a monitor on every decode handshake.
module tb_if_fetch_queue;
  import if_pkg::*;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] imem_addr, imem_data, redirect_pc;
  logic        redirect_valid, out_valid, out_ready, fin;
  logic [31:0] out_instr, out_pc, out_pc4;

  logic [31:0] imem [0:63];
  assign imem_data = imem[imem_addr[7:2]];

  int tests_run    = 0;
  int tests_failed = 0;
  fetch_entry_t exp_q[$];

  if_fetch_queue #(
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (4),
    .HALT_WORD (HALT),
    .FIN_DELAY (7)
  ) dut (
    .CLOCK          (CLOCK),
    .RESET          (RESET),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4),
    .fin            (fin)
  );

  always #5 CLOCK = ~CLOCK;

  // Inputs change at negedge+3; the monitor samples at negedge+4, before the
  // handshake edge, and scores each accepted head against the expected queue.
  always @(negedge CLOCK) begin
    #4;
    if (RESET === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1 &&
        redirect_valid === 1'b0) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_output: pc=%h instr=%h, none expected", out_pc, out_instr);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr || out_pc4 !== e.pc + 32'd4) begin
          tests_failed++;
          $display("FAIL head_entry: got pc=%h instr=%h pc4=%h, want pc=%h instr=%h pc4=%h",
                   out_pc, out_instr, out_pc4, e.pc, e.instr, e.pc + 32'd4);
        end
      end
    end
  end

  task automatic step();
    @(negedge CLOCK);
    #3;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic fill_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'(i + 1);
  endtask

  // Leaves the bench at a sample point with RESET just released.
  task automatic do_reset(input logic rdy);
    step();
    RESET          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = rdy;
    step();
    step();
    exp_q.delete();
    RESET = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while (!(exp_q.size() == 0 && out_valid === 1'b0) && n < 200) begin
      step();
      n++;
    end
    ok = (n < 200);
  endtask

  task automatic count_fin(output int n);
    n = 0;
    while (fin !== 1'b1 && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    fill_imem();
    step();
    RESET          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    step();
    tests_run += 6;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
    if (out_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    if (out_pc4 !== 32'h0) begin tests_failed++; $display("FAIL reset_out_pc4: got %h want 0", out_pc4); end
    if (fin !== 1'b0) begin tests_failed++; $display("FAIL reset_fin: got %b want 0", fin); end
  endtask

  task automatic test_stream_and_fin();
    bit ok;
    int n;
    fill_imem();
    imem[3] = HALT;
    do_reset(1'b1);
    expect_entry(32'h0, 32'h1);
    expect_entry(32'h4, 32'h2);
    expect_entry(32'h8, 32'h3);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_latency0: out_valid got %b want 0", out_valid); end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL stream_first_valid: got valid=%b pc=%h want valid=1 pc=0", out_valid, out_pc);
    end
    wait_drain(ok);
    tests_run++;
    if (!ok || exp_q.size() != 0) begin tests_failed++; $display("FAIL stream_drain: left=%0d ok=%0b want 0 left", exp_q.size(), ok); end
    count_fin(n);
    tests_run++;
    if (n != 7) begin tests_failed++; $display("FAIL fin_delay: got %0d cycles want 7", n); end
    repeat (5) step();
    tests_run += 3;
    if (fin !== 1'b1) begin tests_failed++; $display("FAIL fin_sticky: got %b want 1", fin); end
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_not_enqueued: out_valid got %b want 0", out_valid); end
    if (imem_addr !== 32'hC) begin tests_failed++; $display("FAIL halt_addr_frozen: got %h want c", imem_addr); end
  endtask

  task automatic test_stall();
    bit ok;
    fill_imem();
    imem[5] = HALT;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) expect_entry(32'(4 * i), 32'(i + 1));
    repeat (10) step();
    tests_run += 3;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h1) begin
      tests_failed++;
      $display("FAIL stall_head: got valid=%b pc=%h instr=%h want 1/0/1", out_valid, out_pc, out_instr);
    end
    if (imem_addr !== 32'h10) begin tests_failed++; $display("FAIL stall_addr_hold: got %h want 10", imem_addr); end
    if (exp_q.size() != 5) begin tests_failed++; $display("FAIL stall_no_pop: pending got %0d want 5", exp_q.size()); end
    out_ready = 1'b1;
    wait_drain(ok);
    tests_run++;
    if (!ok || exp_q.size() != 0) begin tests_failed++; $display("FAIL stall_release_drain: left=%0d ok=%0b want 0", exp_q.size(), ok); end
  endtask

  task automatic test_redirect();
    bit ok;
    int n;
    fill_imem();
    imem[19] = HALT;
    do_reset(1'b0);
    repeat (3) step();
    tests_run++;
    if (imem_addr !== 32'hC) begin tests_failed++; $display("FAIL redir_pre_addr: got %h want c", imem_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    out_ready      = 1'b1;
    exp_q.delete();
    expect_entry(32'h40, 32'd17);
    expect_entry(32'h44, 32'd18);
    expect_entry(32'h48, 32'd19);
    step();
    redirect_valid = 1'b0;
    tests_run += 2;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_flush: out_valid got %b want 0", out_valid); end
    if (imem_addr !== 32'h40) begin tests_failed++; $display("FAIL redir_addr: got %h want 40", imem_addr); end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
      tests_failed++;
      $display("FAIL redir_first_head: got valid=%b pc=%h want 1/40", out_valid, out_pc);
    end
    wait_drain(ok);
    count_fin(n);
    tests_run += 2;
    if (!ok || exp_q.size() != 0) begin tests_failed++; $display("FAIL redir_drain: left=%0d want 0", exp_q.size()); end
    if (n != 7) begin tests_failed++; $display("FAIL redir_fin_delay: got %0d want 7", n); end
  endtask

  task automatic test_redirect_during_drain();
    bit ok;
    int n;
    fill_imem();
    imem[1] = HALT;
    imem[9] = HALT;
    do_reset(1'b1);
    expect_entry(32'h0, 32'h1);
    wait_drain(ok);
    repeat (3) step();
    tests_run++;
    if (!ok || fin !== 1'b0) begin tests_failed++; $display("FAIL drain_pre_fin: fin=%b ok=%0b want 0/1", fin, ok); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    expect_entry(32'h20, 32'h9);
    step();
    redirect_valid = 1'b0;
    tests_run += 2;
    if (imem_addr !== 32'h20) begin tests_failed++; $display("FAIL drain_redir_addr: got %h want 20", imem_addr); end
    if (fin !== 1'b0) begin tests_failed++; $display("FAIL drain_redir_fin: got %b want 0", fin); end
    wait_drain(ok);
    tests_run++;
    if (!ok || fin !== 1'b0) begin tests_failed++; $display("FAIL drain_refetch: fin=%b ok=%0b want 0/1", fin, ok); end
    count_fin(n);
    tests_run++;
    if (n != 7) begin tests_failed++; $display("FAIL drain_restart_delay: got %0d want 7", n); end
  endtask

  task automatic test_async_reset();
    fill_imem();
    do_reset(1'b0);
    repeat (6) step();
    tests_run++;
    if (out_valid !== 1'b1 || imem_addr !== 32'h10) begin
      tests_failed++;
      $display("FAIL areset_pre_full: valid=%b addr=%h want 1/10", out_valid, imem_addr);
    end
    RESET = 1'b1;
    #1;
    tests_run += 4;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL areset_addr: got %h want 0", imem_addr); end
    if (fin !== 1'b0) begin tests_failed++; $display("FAIL areset_fin: got %b want 0", fin); end
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      tests_failed++;
      $display("FAIL areset_head: pc=%h instr=%h want 0/0", out_pc, out_instr);
    end
    step();
    RESET = 1'b0;
    step();
  endtask

  initial begin
    RESET          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    test_reset();
    test_stream_and_fin();
    test_stall();
    test_redirect();
    test_redirect_during_drain();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
